// File: rtl/ff_pipe_pkg.sv
// Shared constants and types for the ff_pipe elastic register pipeline.
// Optional occupancy counter is enabled with FF_PIPE_OCC_EN.
package ff_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Width of the occupancy count, which must be able to hold the value DEPTH.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } ff_pipe_stage_t;

endpackage

// File: rtl/ff_pipe_if.sv
// Handshake bundle between ff_pipe and its producer/consumer.
// The occ signal exists only when FF_PIPE_OCC_EN is defined.
interface ff_pipe_ifc
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic clk
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef FF_PIPE_OCC_EN
  logic [occ_width(DEPTH)-1:0] occ;
`endif

  modport dut (
    input  flush, in_valid, in_data, out_ready,
`ifdef FF_PIPE_OCC_EN
    output occ,
`endif
    output in_ready, out_valid, out_data
  );

  modport bench (
    input  clk,
`ifdef FF_PIPE_OCC_EN
    input  occ,
`endif
    input  in_ready, out_valid, out_data,
    output flush, in_valid, in_data, out_ready
  );

endinterface

// File: rtl/ff_pipe_stage.sv
// One pipeline slot: valid flag plus payload register with a load enable.
// Only the valid flag is reset; payload in an empty slot is don't-care.
module ff_pipe_stage
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = up_valid;
      data_d  = up_data;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/ff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both sides,
// bubble collapsing and synchronous flush; FF_PIPE_OCC_EN adds an occupancy count.
module ff_pipe
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic   clk,
  input logic   rst_n,
  ff_pipe_ifc.dut bus
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_ready;
  logic             in_acc;

  // Ready ripples from the consumer back to the producer: a slot can take
  // new data when it is empty or its current word moves on this cycle.
  always_comb begin : ready_chain
    logic ready_down;
    ready_down = bus.out_ready;
    adv        = '0;
    load       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]     = v[k] & ready_down;
      load[k]    = ~v[k] | adv[k];
      ready_down = load[k];
    end
    in_ready = load[0] & ~bus.flush;
  end

  assign in_acc = bus.in_valid & in_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_acc;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = v[k-1];
      assign up_data  = d[k-1];
    end

    ff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush),
      .load     (load[k]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

`ifdef FF_PIPE_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             out_del;

  assign out_del = v[DEPTH-1] & bus.out_ready;

  always_comb begin
    occ_d = occ_q + OCC_W'(in_acc) - OCC_W'(out_del);
    if (bus.flush) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign bus.occ = occ_q;
`endif

endmodule

// File: tb/tb_ff_pipe.sv
// Bench for ff_pipe: directed scenarios then random traffic, checked against
// a word-level model where each stored word tracks its slot position.
module tb_ff_pipe;
  import ff_pipe_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ff_pipe_ifc #(.WIDTH(W), .DEPTH(D)) bus (clk);

  ff_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } ent_t;

  ent_t mq[$];
  bit   known = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   n_acc = 0;
  int   n_del = 0;
  bit   acc, del;
  logic [W-1:0] del_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, predict and compare, then advance the model.
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy,
                      input bit fl, input bit rn);
    ent_t nq[$];
    int   lim, first;
    bit   e_ov, e_ir;
    @(negedge clk);
    rst_n        = rn;
    bus.in_valid = iv;
    bus.in_data  = id;
    bus.out_ready = ordy;
    bus.flush    = fl;
    #1;
    e_ov  = (mq.size() > 0) && (mq[0].pos == D - 1);
    first = (e_ov && ordy) ? 1 : 0;
    lim   = D - 1;
    for (int i = first; i < mq.size(); i++) begin
      ent_t e;
      e = mq[i];
      if (e.pos + 1 <= lim) e.pos++;
      nq.push_back(e);
      lim = e.pos - 1;
    end
    e_ir = !fl && (lim >= 0);
    if (known) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, e_ir});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, e_ov});
      if (e_ov) chk("out_data", {24'd0, bus.out_data}, {24'd0, mq[0].data});
`ifdef FF_PIPE_OCC_EN
      chk("occ", {29'd0, bus.occ}, mq.size());
`endif
    end
    acc      = iv && (bus.in_ready === 1'b1);
    del      = (bus.out_valid === 1'b1) && ordy;
    del_data = bus.out_data;
    if (acc) n_acc++;
    if (del) n_del++;
    last_cyc = cyc;
    @(posedge clk);
    cyc++;
    if (!rn || fl) begin
      mq.delete();
    end else begin
      mq = nq;
      if (iv && e_ir) mq.push_back('{id, 0});
    end
    if (!rn) known = 1'b1;
  endtask

  initial begin
    int w;
    int t_acc, t_out;
    bit d1, d2;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // reset held two cycles with a word offered
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef FF_PIPE_OCC_EN
    chk("rst_occ", {29'd0, bus.occ}, 32'd0);
`endif
    n_del = 0;
    for (int c = 0; c < 6; c++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("rst_no_emerge", n_del, 32'd0);

    // streaming 01..10
    n_acc = 0; n_del = 0; t_acc = -1; t_out = -1;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
      if (i == 1 && acc) t_acc = last_cyc;
      if (del && del_data == 8'h01 && t_out < 0) t_out = last_cyc;
    end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      if (del && del_data == 8'h01 && t_out < 0) t_out = last_cyc;
    end
    chk("stream_acc", n_acc, 32'd16);
    chk("stream_del", n_del, 32'd16);
    chk("stream_latency", t_out - t_acc, 32'd4);

    // back-pressure: six words offered, four fit
    n_acc = 0; n_del = 0; w = 1;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 8'(w), 1'b0, 1'b0, 1'b1);
      if (acc) w++;
    end
    #1;
    chk("bp_acc", n_acc, 32'd4);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int c = 0; c < 20 && n_del < 6; c++) begin
      step(w <= 6, 8'(w), 1'b1, 1'b0, 1'b1);
      if (acc) w++;
    end
    chk("bp_del", n_del, 32'd6);

    // bubble collapse
    n_del = 0;
    step(1'b1, 8'h21, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    chk("bubble_out_valid", {31'd0, bus.out_valid}, 32'd1);
`ifdef FF_PIPE_OCC_EN
    chk("bubble_occ", {29'd0, bus.occ}, 32'd2);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); d1 = del;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); d2 = del;
    chk("bubble_consec", {30'd0, d1, d2}, 32'd3);

    // full pipeline with simultaneous accept and deliver
    n_acc = 0; w = 8'h30;
    for (int c = 0; c < 12 && n_acc < 4; c++) begin
      step(1'b1, 8'(w), 1'b0, 1'b0, 1'b1);
      if (acc) w++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    n_acc = 0; n_del = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 8'(w), 1'b1, 1'b0, 1'b1);
      if (acc) w++;
    end
    chk("full_acc", n_acc, 32'd3);
    chk("full_del", n_del, 32'd3);
`ifdef FF_PIPE_OCC_EN
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    chk("full_occ", {29'd0, bus.occ}, 32'd4);
`endif
    for (int c = 0; c < 20 && n_del < 7; c++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("full_drain", n_del, 32'd7);

    // flush with three words in flight
    n_acc = 0; n_del = 0;
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b1);
    chk("flush_fill", n_acc, 32'd3);
    step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
    chk("flush_no_accept", {31'd0, acc}, 32'd0);
    #1;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef FF_PIPE_OCC_EN
    chk("flush_occ", {29'd0, bus.occ}, 32'd0);
`endif
    for (int c = 0; c < 8; c++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("flush_no_stale", n_del, 32'd0);

    // random traffic including occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 80) != 0);
    end
    for (int c = 0; c < 10; c++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("final_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ff_pipe.md
# ff_pipe

Parametrised elastic register pipeline: `DEPTH` stages of `WIDTH`-bit registers with a valid/ready handshake on both sides. It generalises the single flip-flop into a back-pressure-aware, bubble-collapsing pipeline with a synchronous flush. It sits between any producer/consumer pair in the design and is exercised through its own interface and bench, in the same arrangement as the existing `ff` bench.

## Interface
Parameters:
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 4: number of register stages, ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous clear of all stage contents.
- `in_valid`  in  1  producer has data on `in_data`.
- `in_ready`  out  1  pipeline accepts `in_data` this cycle.
- `in_data`  in  WIDTH  input payload.
- `out_valid`  out  1  last stage holds valid data.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  WIDTH  last-stage payload.
- `occ`  out  $clog2(DEPTH+1)  number of valid stages; present only with `FF_PIPE_OCC_EN`.

## Operation
- Stage k (0 = input, DEPTH-1 = output) holds `v[k]` and `d[k]`.
- Advance rule: `adv[DEPTH-1] = v[DEPTH-1] & out_ready`. `adv[k] = v[k] & (~v[k+1] | adv[k+1])`.
- Stage k loads when `~v[k] | adv[k]`:
  - Stage 0 loads from the input.
  - Stage k>0 loads from stage k-1.
  - On load, `v[k]` takes the upstream valid (`in_valid & in_ready` for stage 0, `v[k-1]` otherwise).
- `in_ready = ~v[0] | adv[0]`. It is combinational from `out_ready` through the ready chain, and it does not depend on `in_valid`.
- Bubbles collapse: an empty stage is filled even while the downstream is stalled.
- Data registers update only on load. Data in an empty stage is don't-care.
- `out_valid = v[DEPTH-1]`, `out_data = d[DEPTH-1]`.
- Flush:
  - All `v[k]` clear at the next edge.
  - `in_ready` is forced to 0 in the flush cycle, so input presented in that cycle is not accepted.
  - `out_valid` still reflects the pre-flush state in that cycle. A transfer completed by `out_ready` in that cycle counts as delivered.
- Ordering: strict FIFO order. No drop or duplication except by flush.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - All `v[k]` = 0.
  - After the edge: `out_valid` = 0, `in_ready` = 1 (if `flush` = 0), `occ` = 0.
  - Data registers are not reset.
  - Reset has priority over flush.
- Reset asserted mid-operation discards all in-flight data at that edge.
- Latency: a word accepted at edge t is visible at the output after edge t+DEPTH-1 when there are no stalls. Minimum `in_valid` → `out_valid` latency is DEPTH cycles.
- Throughput: 1 word/cycle with `out_ready` held high.
- Full (all `v` = 1, `out_ready` = 0): `in_ready` = 0, and all stages hold.
- Full with `out_ready` = 1: simultaneous accept and deliver, so occupancy is unchanged.
- Empty: `out_valid` = 0, and `out_ready` is ignored.
- DEPTH = 1 degenerates to a single registered stage with `in_ready = ~v[0] | out_ready`.

## Configuration
- `FF_PIPE_OCC_EN` defined:
  - `occ` port exists as a registered counter.
  - Next value = `occ` + (input accept) − (output deliver). Cleared to 0 by reset or flush.
  - Never exceeds DEPTH.
- Not defined: the `occ` port and counter are absent. All other behaviour is identical.

## Structure
- Package `ff_pipe_pkg`:
  - Default `WIDTH`/`DEPTH` constants.
  - `occ_t` width function `$clog2(DEPTH+1)`.
  - The `ff_pipe_stage_t` typedef struct {valid, data}.
- Sub-module `ff_pipe_stage`: one valid/data register with load enable. `ff_pipe` instantiates DEPTH of these in a generate loop and builds the advance/ready chain.
- Bench follows the existing arrangement: interface `ff_pipe_ifc(clk)` with `dut`/`bench` modports, a top that instantiates dut and bench, clock period 10 ns.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset:
  - Stimulus: hold `rst_n` = 0 for 2 cycles with `in_valid` = 1, `in_data` = 8'hAA.
  - Response: `out_valid` = 0, `occ` = 0, nothing emerges after release until a new accept.
- Streaming:
  - Stimulus: send 8'h01..8'h10 back-to-back, `out_ready` = 1.
  - Response: the first word appears 4 cycles after its accept, then one word per cycle in order, with `in_ready` constantly 1.
- Back-pressure:
  - Stimulus: `out_ready` = 0, send 6 words.
  - Response: exactly 4 are accepted (`occ` = 4) and `in_ready` = 0. After raising `out_ready`, 8'h01..8'h06 drain in order, none lost.
- Bubble collapse:
  - Stimulus: send one word, stall the output, wait 2 cycles, send a second word.
  - Response: the words sit in stages 3 and 2 (`occ` = 2). On release they are delivered on consecutive cycles.
- Simultaneous full accept/deliver:
  - Stimulus: with the pipeline full, assert `in_valid` and `out_ready` together for 3 cycles.
  - Response: `occ` stays 4, 3 words out, 3 in, order preserved.
- Flush:
  - Stimulus: with 3 words in flight, pulse `flush` for 1 cycle with `in_valid` = 1.
  - Response: the flush-cycle input is not accepted, `out_valid` = 0 and `occ` = 0 the next cycle, and no stale word ever appears.
